ifu_align_buf: RTL

Halfword-granular instruction alignment buffer between the IFU fetch path and the compressed-instruction expander / decode. It accepts 32-bit fetch packets with per-halfword valids, queues halfwords with their PCs, and presents one whole instruction per cycle. That instruction is either a 16-bit compressed halfword or a 32-bit instruction reassembled across packet boundaries, with its PC and size flag. A flush discards all queued state when fetch redirects.

---
 rtl/ifu_align_buf_pkg.sv | 17 +
 rtl/ifu_align_hwq.sv | 71 +++++++
 rtl/ifu_align_buf.sv | 83 ++++++++
 3 files changed

// File: rtl/ifu_align_buf_pkg.sv
// Shared IFU alignment types: one queued halfword with the PC it was fetched at.
package ifu_align_buf_pkg;

    localparam int ALIGN_HW_W = 16;
    localparam int ALIGN_PC_W = 31;

    typedef struct packed {
        logic [ALIGN_HW_W-1:0] hw;
        logic [ALIGN_PC_W-1:0] pc;
    } ifu_hw_entry_t;

    // RISC-V length encoding: low bits 2'b11 mark a 32-bit instruction.
    function automatic logic hw_is_32b(input logic [ALIGN_HW_W-1:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/ifu_align_hwq.sv
// Dual-push halfword FIFO: up to two writes per cycle, peek of head and head+1,
// pop by one or two entries.
module ifu_align_hwq
    import ifu_align_buf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         wr_lo_en_i,
    input  logic                         wr_hi_en_i,
    input  ifu_hw_entry_t                wr_lo_i,
    input  ifu_hw_entry_t                wr_hi_i,
    input  logic                         pop1_i,
    input  logic                         pop2_i,
    output ifu_hw_entry_t                head_o,
    output logic [ALIGN_HW_W-1:0]        head_n1_hw_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifu_hw_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [AW-1:0] wr_hi_idx;
    logic [AW-1:0] rd_n1;
    logic          clear;

    assign clear     = rst | flush_i;
    assign push_n    = {1'b0, wr_lo_en_i} + {1'b0, wr_hi_en_i};
    assign pop_n     = pop2_i ? 2'd2 : (pop1_i ? 2'd1 : 2'd0);
    // An upper-only packet lands in the slot the lower half would have used.
    assign wr_hi_idx = wr_lo_en_i ? (wr_q + 1'b1) : wr_q;
    assign rd_n1     = rd_q + 1'b1;

    always_comb begin
        wr_d    = wr_q + AW'(push_n);
        rd_d    = rd_q + AW'(pop_n);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (wr_lo_en_i) mem_q[wr_q]      <= wr_lo_i;
            if (wr_hi_en_i) mem_q[wr_hi_idx] <= wr_hi_i;
        end
    end

    assign head_o       = mem_q[rd_q];
    assign head_n1_hw_o = mem_q[rd_n1].hw;
    assign count_o      = count_q;

endmodule

// File: rtl/ifu_align_buf.sv
// Instruction alignment buffer: queues fetched halfwords and presents one whole
// 16- or 32-bit instruction per cycle, reassembling across packet boundaries.
module ifu_align_buf
    import ifu_align_buf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic [1:0]  fetch_hw_valid,
    input  logic [30:0] fetch_pc,
    output logic        ifu_i0_valid,
    input  logic        ifu_i0_ready,
    output logic [31:0] ifu_i0_instr,
    output logic [15:0] ifu_i0_cinst,
    output logic [30:0] ifu_i0_pc,
    output logic        ifu_i0_pc4
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both
    // high; valid never depends on ready, and fetch_ready depends only on
    // registered occupancy so there is no ready-to-ready combinational path.

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ifu_hw_entry_t       head;
    ifu_hw_entry_t       wr_lo, wr_hi;
    logic [ALIGN_HW_W-1:0] head_n1_hw;
    logic [CW-1:0]       count;
    logic [CW-1:0]       free_slots;
    logic                push_fire;
    logic                head_is32;
    logic                pop_fire;

    assign free_slots  = DEPTH_C - count;
    // Two free slots are always reserved so a full packet can never overflow.
    assign fetch_ready = !rst && (free_slots >= CW'(2));
    assign push_fire   = fetch_valid && fetch_ready && !flush;

    assign wr_lo = '{hw: fetch_data[15:0],  pc: fetch_pc};
    assign wr_hi = '{hw: fetch_data[31:16], pc: fetch_pc + 31'd1};

    assign head_is32    = hw_is_32b(head.hw);
    assign ifu_i0_valid = !rst && !flush &&
                          (((count >= CW'(1)) && !head_is32) || (count >= CW'(2)));
    assign pop_fire     = ifu_i0_valid && ifu_i0_ready;

    ifu_align_hwq #(
        .DEPTH (DEPTH)
    ) u_hwq (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .wr_lo_en_i   (push_fire && fetch_hw_valid[0]),
        .wr_hi_en_i   (push_fire && fetch_hw_valid[1]),
        .wr_lo_i      (wr_lo),
        .wr_hi_i      (wr_hi),
        .pop1_i       (pop_fire && !head_is32),
        .pop2_i       (pop_fire && head_is32),
        .head_o       (head),
        .head_n1_hw_o (head_n1_hw),
        .count_o      (count)
    );

    always_comb begin
        ifu_i0_instr = '0;
        ifu_i0_cinst = '0;
        ifu_i0_pc    = '0;
        ifu_i0_pc4   = 1'b0;
        if (ifu_i0_valid) begin
            ifu_i0_instr = head_is32 ? {head_n1_hw, head.hw} : {16'h0000, head.hw};
            ifu_i0_cinst = head.hw;
            ifu_i0_pc    = head.pc;
            ifu_i0_pc4   = head_is32;
        end
    end

endmodule
